// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared wave-scheduler state enum, enemy limits and speed schedule
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPAWNING,
    ACTIVE,
    CLEARED
  } waveState_t;

  localparam int MAX_ENEMIES        = 8;
  localparam int DEFAULT_BASE_SPEED = 64;
  localparam int DEFAULT_SPEED_STEP = 16;
  localparam int DEFAULT_MAX_SPEED  = 256;

  // Raw speed is formed at 12 bits so that a large level*step cannot wrap before the clamp.
  function automatic logic [10:0] clampSpeed(input logic [3:0] lvl, input int base,
                                             input int step, input int maxSpeed);
    logic [11:0] raw;
    raw = 12'(base) + 12'(lvl) * 12'(step);
    return (raw > 12'(maxSpeed)) ? 11'(maxSpeed) : 11'(raw);
  endfunction

endpackage

// File: rtl/enemy_pickAlive.sv
// rtl/enemy_pickAlive.sv - round-robin first-alive finder starting at a given index
module enemy_pickAlive #(
  parameter int NUM = 2
) (
  input  logic [NUM-1:0] map,
  input  logic [3:0]     start,
  output logic           found,
  output logic [3:0]     index
);

  logic [4:0]     pos;
  logic [NUM-1:0] shifted;

  // start is always below NUM, so a single subtract is enough to wrap.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = '0;
    shifted = '0;
    for (int k = 0; k < NUM; k++) begin
      pos = 5'(start) + 5'(k);
      if (pos >= 5'(NUM)) pos = pos - 5'(NUM);
      shifted = map >> pos;
      if (!found && shifted[0]) begin
        found = 1'b1;
        index = pos[3:0];
      end
    end
  end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// rtl/enemy_wave_scheduler.sv - spawns a wave of enemies, schedules their fire, tracks level and speed
module enemy_wave_scheduler
  import enemy_pkg::*;
#(
  parameter int AMOUNT_OF_ENEMIES = 2,
  parameter int SPAWN_GAP_FRAMES  = 30,
  parameter int FIRE_GAP_FRAMES   = 60,
  parameter int BASE_SPEED        = DEFAULT_BASE_SPEED,
  parameter int SPEED_STEP        = DEFAULT_SPEED_STEP,
  parameter int MAX_SPEED         = DEFAULT_MAX_SPEED
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         newLevel,
  input  logic                         pause,
  input  logic                         hitValid,
  input  logic [3:0]                   hitId,
  input  logic [10:0]                  RNG,
  input  logic                         fireAck,
  output logic [AMOUNT_OF_ENEMIES-1:0] aliveMap,
  output logic                         spawnPulse,
  output logic [3:0]                   spawnId,
  output logic                         fireReq,
  output logic [3:0]                   fireId,
  output logic [10:0]                  enemySpeed,
  output logic                         levelCleared,
  output logic [3:0]                   level
);

  localparam int N  = AMOUNT_OF_ENEMIES;
  localparam int SW = $clog2(SPAWN_GAP_FRAMES + 1);
  localparam int FW = $clog2(FIRE_GAP_FRAMES + 1);

  waveState_t     state, stateNext;
  logic [3:0]     spawnIdx, spawnIdxNext;
  logic [SW-1:0]  frameCnt, frameCntNext;
  logic [FW-1:0]  fireCnt, fireCntNext;
  logic [N-1:0]   aliveNext, hitMask, spawnMask, survivors;
  logic           fireReqNext, spawnPulseNext, levelClearedNext;
  logic [3:0]     fireIdNext, spawnIdNext, levelNext;
  logic           sof, hitInRange, pickFound;
  logic [3:0]     startIdx, pickIdx;
  logic           unusedRng;

  assign unusedRng  = ^RNG[10:4];
  assign sof        = startOfFrame && !pause;
  assign hitInRange = hitValid && (32'(hitId) < N);
  assign hitMask    = hitInRange ? (N'(1) << hitId) : '0;
  assign spawnMask  = N'(1) << spawnIdx;
  assign survivors  = aliveMap & ~hitMask;
  assign startIdx   = 4'(int'(RNG[3:0]) % N);

  enemy_pickAlive #(.NUM(N)) picker (
    .map   (survivors),
    .start (startIdx),
    .found (pickFound),
    .index (pickIdx)
  );

  always_comb begin
    stateNext        = state;
    aliveNext        = aliveMap;
    spawnIdxNext     = spawnIdx;
    frameCntNext     = frameCnt;
    fireCntNext      = fireCnt;
    fireReqNext      = fireReq;
    fireIdNext       = fireId;
    spawnPulseNext   = 1'b0;
    spawnIdNext      = spawnId;
    levelClearedNext = 1'b0;
    levelNext        = level;

    case (state)
      SPAWNING: begin
        aliveNext = survivors;
        if (spawnIdx == 4'(N)) begin
          if (!pause) stateNext = ACTIVE;
        end else if (sof) begin
          // Enemy 0 appears on the first frame; later ones wait a full gap.
          if (spawnIdx == 4'd0 || frameCnt == SW'(SPAWN_GAP_FRAMES - 1)) begin
            aliveNext      = survivors | spawnMask;
            spawnPulseNext = 1'b1;
            spawnIdNext    = spawnIdx;
            spawnIdxNext   = spawnIdx + 4'd1;
            frameCntNext   = '0;
          end else begin
            frameCntNext = frameCnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!pause && aliveMap == '0) begin
          stateNext        = CLEARED;
          levelClearedNext = 1'b1;
          levelNext        = (level == 4'd15) ? level : level + 4'd1;
          fireReqNext      = 1'b0;
        end else begin
          aliveNext = survivors;
          if (fireReq) begin
            if (fireAck || (hitValid && hitId == fireId)) fireReqNext = 1'b0;
          end else if (sof) begin
            if (fireCnt == FW'(FIRE_GAP_FRAMES - 1)) begin
              fireCntNext = '0;
              if (pickFound) begin
                fireReqNext = 1'b1;
                fireIdNext  = pickIdx;
              end
            end else begin
              fireCntNext = fireCnt + 1'b1;
            end
          end
        end
      end
      CLEARED: begin
        if (!pause) stateNext = IDLE;
      end
      default: ;
    endcase

    if (newLevel) begin
      stateNext        = SPAWNING;
      aliveNext        = '0;
      spawnIdxNext     = '0;
      frameCntNext     = '0;
      fireCntNext      = '0;
      fireReqNext      = 1'b0;
      spawnPulseNext   = 1'b0;
      levelClearedNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      aliveMap     <= '0;
      spawnIdx     <= '0;
      frameCnt     <= '0;
      fireCnt      <= '0;
      spawnPulse   <= 1'b0;
      spawnId      <= '0;
      fireReq      <= 1'b0;
      fireId       <= '0;
      levelCleared <= 1'b0;
      level        <= '0;
      enemySpeed   <= 11'(BASE_SPEED);
    end else begin
      state        <= stateNext;
      aliveMap     <= aliveNext;
      spawnIdx     <= spawnIdxNext;
      frameCnt     <= frameCntNext;
      fireCnt      <= fireCntNext;
      spawnPulse   <= spawnPulseNext;
      spawnId      <= spawnIdNext;
      fireReq      <= fireReqNext;
      fireId       <= fireIdNext;
      levelCleared <= levelClearedNext;
      level        <= levelNext;
      enemySpeed   <= clampSpeed(level, BASE_SPEED, SPEED_STEP, MAX_SPEED);
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// tb/tb_enemy_wave_scheduler.sv - directed and randomized checks of enemy_wave_scheduler against a frame-level model
module tb_enemy_wave_scheduler;

  localparam int N  = 2;
  localparam int SG = 4;
  localparam int FG = 8;
  localparam int PH_IDLE = 0, PH_SPAWN = 1, PH_ACTIVE = 2, PH_CLEARED = 3;

  logic         clk = 1'b0;
  logic         reset, startOfFrame, newLevel, pause, hitValid, fireAck;
  logic [3:0]   hitId;
  logic [10:0]  RNG;
  logic [N-1:0] aliveMap;
  logic         spawnPulse, fireReq, levelCleared;
  logic [3:0]   spawnId, fireId, level;
  logic [10:0]  enemySpeed;

  always #5 clk = ~clk;

  enemy_wave_scheduler #(
    .AMOUNT_OF_ENEMIES (N),
    .SPAWN_GAP_FRAMES  (SG),
    .FIRE_GAP_FRAMES   (FG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .newLevel     (newLevel),
    .pause        (pause),
    .hitValid     (hitValid),
    .hitId        (hitId),
    .RNG          (RNG),
    .fireAck      (fireAck),
    .aliveMap     (aliveMap),
    .spawnPulse   (spawnPulse),
    .spawnId      (spawnId),
    .fireReq      (fireReq),
    .fireId       (fireId),
    .enemySpeed   (enemySpeed),
    .levelCleared (levelCleared),
    .level        (level)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame-level reference: spawns at unpaused wave frames 1, 1+SG, 1+2*SG ...; fires every FG unpaused active frames.
  int           mPhase, mSpawned, mWaveFrames, mFireFrames, mSpawnId, mFireId, mLevel, mSpeed;
  logic [N-1:0] mAlive;
  bit           mPulse, mFireReq, mCleared;

  task automatic modelReset();
    mPhase = PH_IDLE; mSpawned = 0; mWaveFrames = 0; mFireFrames = 0;
    mSpawnId = 0; mFireId = 0; mLevel = 0; mSpeed = 64;
    mAlive = '0; mPulse = 0; mFireReq = 0; mCleared = 0;
  endtask

  task automatic modelStep();
    logic [N-1:0] hitMask;
    bit           frameOk, found;
    int           start, idx;
    if (reset) begin
      modelReset();
      return;
    end
    hitMask = '0;
    for (int i = 0; i < N; i++) if (hitValid && int'(hitId) == i) hitMask[i] = 1'b1;
    mPulse   = 0;
    mCleared = 0;
    mSpeed   = (64 + mLevel * 16 > 256) ? 256 : 64 + mLevel * 16;
    frameOk  = startOfFrame && !pause;
    if (newLevel) begin
      mPhase = PH_SPAWN; mAlive = '0; mSpawned = 0; mWaveFrames = 0; mFireFrames = 0; mFireReq = 0;
      return;
    end
    case (mPhase)
      PH_SPAWN: begin
        mAlive = mAlive & ~hitMask;
        if (mSpawned == N) begin
          if (!pause) mPhase = PH_ACTIVE;
        end else if (frameOk) begin
          mWaveFrames++;
          if (mWaveFrames == 1 + mSpawned * SG) begin
            mAlive[mSpawned] = 1'b1;
            mPulse = 1;
            mSpawnId = mSpawned;
            mSpawned++;
          end
        end
      end
      PH_ACTIVE: begin
        if (!pause && mAlive == '0) begin
          mPhase = PH_CLEARED; mCleared = 1; mFireReq = 0;
          if (mLevel < 15) mLevel++;
        end else begin
          mAlive = mAlive & ~hitMask;
          if (mFireReq) begin
            if (fireAck || (hitValid && int'(hitId) == mFireId)) mFireReq = 0;
          end else if (frameOk) begin
            mFireFrames++;
            if (mFireFrames == FG) begin
              mFireFrames = 0;
              start = int'(RNG[3:0]) % N;
              found = 0;
              for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (!found && mAlive[idx]) begin
                  found = 1; mFireReq = 1; mFireId = idx;
                end
              end
            end
          end
        end
      end
      PH_CLEARED: if (!pause) mPhase = PH_IDLE;
      default: ;
    endcase
  endtask

  task automatic compareAll();
    checkVal("aliveMap", 32'(aliveMap), 32'(mAlive));
    checkVal("spawnPulse", 32'(spawnPulse), 32'(mPulse));
    checkVal("spawnId", 32'(spawnId), mSpawnId);
    checkVal("fireReq", 32'(fireReq), 32'(mFireReq));
    checkVal("fireId", 32'(fireId), mFireId);
    checkVal("levelCleared", 32'(levelCleared), 32'(mCleared));
    checkVal("level", 32'(level), mLevel);
    checkVal("enemySpeed", 32'(enemySpeed), mSpeed);
  endtask

  task automatic cycle(input logic rst, input logic sofIn, input logic nl, input logic pz,
                       input logic hv, input logic [3:0] hid, input logic [10:0] rng, input logic ack);
    reset = rst; startOfFrame = sofIn; newLevel = nl; pause = pz;
    hitValid = hv; hitId = hid; RNG = rng; fireAck = ack;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  logic        curPause = 1'b0;
  logic [10:0] curRng = 11'd0;

  task automatic sofCyc();            cycle(0, 1, 0, curPause, 0, 4'd0, curRng, 0); endtask
  task automatic idle(input int n);   repeat (n) cycle(0, 0, 0, curPause, 0, 4'd0, curRng, 0); endtask
  task automatic hitCyc(input int id); cycle(0, 0, 0, curPause, 1, 4'(id), curRng, 0); endtask
  task automatic ackCyc();            cycle(0, 0, 0, curPause, 0, 4'd0, curRng, 1); endtask
  task automatic nlCyc();             cycle(0, 0, 1, curPause, 0, 4'd0, curRng, 0); endtask

  int pulses, clears;
  bit pzState;

  initial begin
    modelReset();
    repeat (3) cycle(1, 0, 0, 0, 0, 4'd0, 11'd0, 0);
    checkVal("rst_speed", 32'(enemySpeed), 64);
    checkVal("rst_alive", 32'(aliveMap), 0);
    checkVal("rst_fireReq", 32'(fireReq), 0);
    idle(2);

    // Wave start: spawn at frames 1 and 5
    nlCyc();
    sofCyc(); checkVal("spawn0_pulse", 32'(spawnPulse), 1); checkVal("spawn0_id", 32'(spawnId), 0); idle(1);
    pulses = 0;
    repeat (3) begin sofCyc(); pulses += int'(spawnPulse); idle(1); end
    checkVal("gap_no_spawn", pulses, 0);
    sofCyc(); checkVal("spawn1_pulse", 32'(spawnPulse), 1); checkVal("spawn1_id", 32'(spawnId), 1);
    idle(1);
    checkVal("both_alive", 32'(aliveMap), 3);

    // Fire on id 1, then the target is shot while pending
    curRng = 11'd1;
    repeat (7) begin sofCyc(); idle(1); end
    checkVal("fire_not_early", 32'(fireReq), 0);
    sofCyc(); checkVal("fire1_req", 32'(fireReq), 1); checkVal("fire1_id", 32'(fireId), 1);
    idle(2);
    hitCyc(1); checkVal("fire1_dropped", 32'(fireReq), 0); checkVal("alive_after_hit1", 32'(aliveMap), 1);

    // Fire wraps to id 0, held until ack
    repeat (8) begin sofCyc(); idle(1); end
    checkVal("fire0_req", 32'(fireReq), 1); checkVal("fire0_id", 32'(fireId), 0);
    idle(3); checkVal("fire0_held", 32'(fireReq), 1);
    ackCyc(); checkVal("fire0_acked", 32'(fireReq), 0);

    // Restart mid-spawn, then pause for 20 frames
    nlCyc(); sofCyc(); idle(1);
    nlCyc(); checkVal("restart_alive", 32'(aliveMap), 0); checkVal("restart_level", 32'(level), 0);
    sofCyc(); checkVal("restart_spawn0", 32'(spawnPulse), 1); checkVal("restart_id0", 32'(spawnId), 0);
    idle(1);
    repeat (2) begin sofCyc(); idle(1); end
    curPause = 1'b1; pulses = 0;
    repeat (20) begin sofCyc(); pulses += int'(spawnPulse); idle(1); pulses += int'(spawnPulse); end
    checkVal("pause_no_spawn", pulses, 0);
    curPause = 1'b0;
    sofCyc(); checkVal("resume_no_spawn", 32'(spawnPulse), 0); idle(1);
    sofCyc(); checkVal("resume_spawn1", 32'(spawnPulse), 1); checkVal("resume_id1", 32'(spawnId), 1);
    idle(1);

    // Clear the wave
    clears = 0;
    hitCyc(0); clears += int'(levelCleared);
    hitCyc(1); clears += int'(levelCleared);
    repeat (4) begin idle(1); clears += int'(levelCleared); end
    checkVal("single_clear", clears, 1);
    checkVal("level_one", 32'(level), 1);
    checkVal("speed_80", 32'(enemySpeed), 80);

    // Randomized traffic
    pzState = 0;
    for (int c = 0; c < 8000; c++) begin
      logic rst, s, nl, hv, ak;
      if (pzState) pzState = ($urandom_range(0, 9) != 0);
      else         pzState = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 3999) == 0);
      s   = ($urandom_range(0, 2) == 0);
      nl  = (mPhase == PH_IDLE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 599) == 0);
      hv  = ($urandom_range(0, 14) == 0);
      ak  = ($urandom_range(0, 3) == 0);
      cycle(rst, s, nl, pzState, hv, 4'($urandom_range(0, 3)), 11'($urandom), ak);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
